// File: rtl/rom_arb_pkg.sv
// Shared types and default sizes for the program-ROM arbiter.
// Owner tags identify which port a ROM read in flight belongs to.
// Default widths mirror the processor ROM geometry.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_B_MAX_WAIT = 4;
    localparam int WAIT_CNT_WIDTH = 4;

endpackage

// File: rtl/rom_arb_wait_counter.sv
// Saturating starvation counter for the secondary ROM reader.
// Latency: expired reflects the registered count, valid the cycle after the last inc.
// No backpressure: clr has priority over inc; count saturates at MAX_WAIT.
module rom_arb_wait_counter
    import rom_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_B_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    localparam logic [WAIT_CNT_WIDTH-1:0] MAX_CNT = WAIT_CNT_WIDTH'(MAX_WAIT);

    logic [WAIT_CNT_WIDTH-1:0] cnt;

    // Count consecutive denied cycles; stop at the limit so expired stays high until B wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_CNT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == MAX_CNT);

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single-port synchronous program ROM between fetch (A) and a secondary reader (B).
// Latency: GNT in cycle N -> VALID/DATA in cycle N+2, fully pipelined.
// Requesters hold REQ until GNT; A has priority unless B has been denied B_MAX_WAIT cycles.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int B_MAX_WAIT = DEF_B_MAX_WAIT
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  A_REQ,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    output logic                  A_GNT,
    output logic                  A_VALID,
    output logic [DATA_WIDTH-1:0] A_DATA,
    input  logic                  B_REQ,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    output logic                  B_GNT,
    output logic                  B_VALID,
    output logic [DATA_WIDTH-1:0] B_DATA,
    output logic [ADDR_WIDTH-1:0] ROM_ADDR,
    input  logic [DATA_WIDTH-1:0] ROM_DATA
);

    owner_t                owner;
    owner_t                tag0;
    logic                  b_expired;
    logic [ADDR_WIDTH-1:0] last_addr;

    rom_arb_wait_counter #(
        .MAX_WAIT (B_MAX_WAIT)
    ) u_wait (
        .clk     (CLK),
        .rst     (RESET),
        .inc     (B_REQ & ~B_GNT),
        .clr     (~B_REQ | B_GNT),
        .expired (b_expired)
    );

    // Pick this cycle's owner: A by default, B when alone or when its wait has run out.
    always_comb begin
        owner = OWN_NONE;
        if (!RESET) begin
            if (B_REQ && (!A_REQ || b_expired)) begin
                owner = OWN_B;
            end else if (A_REQ) begin
                owner = OWN_A;
            end
        end
    end

    assign A_GNT = (owner == OWN_A);
    assign B_GNT = (owner == OWN_B);

    // Drive the granted address; an idle cycle keeps the ROM pointed at the last read.
    always_comb begin
        ROM_ADDR = last_addr;
        case (owner)
            OWN_A:   ROM_ADDR = A_ADDR;
            OWN_B:   ROM_ADDR = B_ADDR;
            default: ROM_ADDR = last_addr;
        endcase
    end

    // Remember the last issued address and tag who owns the read now in the ROM.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_addr <= '0;
            tag0      <= OWN_NONE;
        end else begin
            tag0 <= owner;
            if (owner != OWN_NONE) begin
                last_addr <= ROM_ADDR;
            end
        end
    end

    // Land the ROM word on port A when A owned the read; data holds between strobes.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            A_VALID <= 1'b0;
            A_DATA  <= '0;
        end else begin
            A_VALID <= (tag0 == OWN_A);
            if (tag0 == OWN_A) begin
                A_DATA <= ROM_DATA;
            end
        end
    end

    // Land the ROM word on port B when B owned the read; data holds between strobes.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            B_VALID <= 1'b0;
            B_DATA  <= '0;
        end else begin
            B_VALID <= (tag0 == OWN_B);
            if (tag0 == OWN_B) begin
                B_DATA <= ROM_DATA;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: two instances (B_MAX_WAIT 4 and 1) share stimulus.
// Each cycle is predicted by a transaction-level model (grant choice, read queue, held words).
// Each scenario task compares the full observable state of both instances inline.
module tb_rom_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       A_REQ = 1'b0;
    logic       B_REQ = 1'b0;
    logic [7:0] A_ADDR = 8'h00;
    logic [7:0] B_ADDR = 8'h00;

    logic [1:0] a_gnt, b_gnt, a_valid, b_valid;
    logic [7:0] a_data [2];
    logic [7:0] b_data [2];
    logic [7:0] rom_addr [2];
    logic [7:0] rom_q [2];
    logic [7:0] rom [256];

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    rom_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .B_MAX_WAIT(4)) dut0 (
        .CLK(CLK), .RESET(RESET),
        .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_GNT(a_gnt[0]), .A_VALID(a_valid[0]), .A_DATA(a_data[0]),
        .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_GNT(b_gnt[0]), .B_VALID(b_valid[0]), .B_DATA(b_data[0]),
        .ROM_ADDR(rom_addr[0]), .ROM_DATA(rom_q[0])
    );

    rom_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .B_MAX_WAIT(1)) dut1 (
        .CLK(CLK), .RESET(RESET),
        .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_GNT(a_gnt[1]), .A_VALID(a_valid[1]), .A_DATA(a_data[1]),
        .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_GNT(b_gnt[1]), .B_VALID(b_valid[1]), .B_DATA(b_data[1]),
        .ROM_ADDR(rom_addr[1]), .ROM_DATA(rom_q[1])
    );

    // Synchronous-read ROMs, one per instance, one cycle of read latency.
    always @(posedge CLK) begin
        rom_q[0] <= rom[rom_addr[0]];
        rom_q[1] <= rom[rom_addr[1]];
    end

    // ---------------- reference model ----------------
    // owner codes in the model: 0 none, 1 A, 2 B
    int         denied [2];
    logic [7:0] m_last [2];
    int         q_own [2][$];
    logic [7:0] q_addr [2][$];
    logic [7:0] hold_a [2];
    logic [7:0] hold_b [2];
    int         cur_own [2];
    logic [7:0] cur_addr [2];
    logic [27:0] exp_vec [2];

    function automatic int max_wait(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [27:0] obs(input int k);
        return {a_gnt[k], b_gnt[k], rom_addr[k], a_valid[k], b_valid[k], a_data[k], b_data[k]};
    endfunction

    // Apply one cycle of inputs and predict what both instances show during it.
    task automatic cycle_begin(input logic rst_i, input logic ar, input logic [7:0] aa,
                               input logic br, input logic [7:0] ba);
        logic va, vb;
        int   o;
        logic [7:0] ad;
        RESET  = rst_i;
        A_REQ  = ar;
        A_ADDR = aa;
        B_REQ  = br;
        B_ADDR = ba;
        for (int k = 0; k < 2; k++) begin
            va = 1'b0;
            vb = 1'b0;
            if (rst_i) begin
                denied[k] = 0;
                m_last[k] = 8'h00;
                q_own[k].delete();
                q_addr[k].delete();
                hold_a[k] = 8'h00;
                hold_b[k] = 8'h00;
                cur_own[k] = 0;
                cur_addr[k] = 8'h00;
            end else begin
                if (br && (!ar || denied[k] >= max_wait(k))) begin
                    cur_own[k] = 2; cur_addr[k] = ba;
                end else if (ar) begin
                    cur_own[k] = 1; cur_addr[k] = aa;
                end else begin
                    cur_own[k] = 0; cur_addr[k] = m_last[k];
                end
                // the read issued two cycles ago is delivered now
                if (q_own[k].size() == 2) begin
                    o  = q_own[k].pop_front();
                    ad = q_addr[k].pop_front();
                    if (o == 1) begin va = 1'b1; hold_a[k] = rom[ad]; end
                    if (o == 2) begin vb = 1'b1; hold_b[k] = rom[ad]; end
                end
            end
            exp_vec[k] = {cur_own[k] == 1, cur_own[k] == 2, cur_addr[k], va, vb, hold_a[k], hold_b[k]};
        end
        #1;
    endtask

    // Clock edge: commit the model's issued read, address memory and wait count.
    task automatic cycle_end();
        int d;
        @(posedge CLK);
        for (int k = 0; k < 2; k++) begin
            if (!RESET) begin
                q_own[k].push_back(cur_own[k]);
                q_addr[k].push_back(cur_addr[k]);
                if (cur_own[k] != 0) m_last[k] = cur_addr[k];
                if (B_REQ && cur_own[k] != 2) begin
                    d = denied[k] + 1;
                    denied[k] = (d > max_wait(k)) ? max_wait(k) : d;
                end else begin
                    denied[k] = 0;
                end
            end
        end
        @(negedge CLK);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle_begin(1'b1, 1'b1, 8'($urandom), 1'b1, 8'($urandom));
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== 28'h0) begin
                    miscompares++;
                    $display("FAIL reset_state dut%0d cyc%0d: got %h want %h", k, i, obs(k), 28'h0);
                end
            end
            cycle_end();
        end
        for (int i = 0; i < 8; i++) begin
            if (i < 3)       cycle_begin(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 8'h00);
            else if (i == 3) cycle_begin(1'b1, 1'b1, 8'h55, 1'b1, 8'h66);
            else             cycle_begin(1'b0, 1'b0, 8'($urandom), 1'b0, 8'($urandom));
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== exp_vec[k]) begin
                    miscompares++;
                    $display("FAIL reset_mid dut%0d cyc%0d: got %h want %h", k, i, obs(k), exp_vec[k]);
                end
            end
            if (i == 4 || i == 5) begin
                vectors++;
                if ({a_valid, b_valid} !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL reset_stale_valid cyc%0d: got %b want 0000", i, {a_valid, b_valid});
                end
            end
            cycle_end();
        end
    endtask

    task automatic test_a_only();
        for (int i = 0; i < 7; i++) begin
            if (i < 3) cycle_begin(1'b0, 1'b1, 8'(i), 1'b0, 8'($urandom));
            else       cycle_begin(1'b0, 1'b0, 8'($urandom), 1'b0, 8'($urandom));
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== exp_vec[k]) begin
                    miscompares++;
                    $display("FAIL a_only dut%0d cyc%0d: got %h want %h", k, i, obs(k), exp_vec[k]);
                end
            end
            if (i >= 2 && i <= 4) begin
                vectors++;
                if ({a_valid[0], a_data[0]} !== {1'b1, rom[i - 2]}) begin
                    miscompares++;
                    $display("FAIL a_only_word cyc%0d: got %b/%h want 1/%h", i, a_valid[0], a_data[0], rom[i - 2]);
                end
            end
            cycle_end();
        end
    endtask

    task automatic test_b_only();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) cycle_begin(1'b0, 1'b0, 8'($urandom), 1'b1, 8'h10);
            else        cycle_begin(1'b0, 1'b0, 8'($urandom), 1'b0, 8'($urandom));
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== exp_vec[k]) begin
                    miscompares++;
                    $display("FAIL b_only dut%0d cyc%0d: got %h want %h", k, i, obs(k), exp_vec[k]);
                end
            end
            if (i >= 2) begin
                vectors++;
                if ({b_valid[0], b_data[0]} !== {i == 2, rom[8'h10]}) begin
                    miscompares++;
                    $display("FAIL b_only_hold cyc%0d: got %b/%h want %b/%h", i, b_valid[0], b_data[0], i == 2, rom[8'h10]);
                end
            end
            cycle_end();
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 18; i++) begin
            if (i < 15) cycle_begin(1'b0, 1'b1, 8'($urandom), 1'b1, 8'($urandom));
            else        cycle_begin(1'b0, 1'b0, 8'($urandom), 1'b0, 8'($urandom));
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== exp_vec[k]) begin
                    miscompares++;
                    $display("FAIL contention dut%0d cyc%0d: got %h want %h", k, i, obs(k), exp_vec[k]);
                end
            end
            if (i < 15) begin
                vectors++;
                if ({b_gnt[0], b_gnt[1]} !== {i % 5 == 4, i % 2 == 1}) begin
                    miscompares++;
                    $display("FAIL contention_pattern cyc%0d: got %b want %b", i, {b_gnt[0], b_gnt[1]}, {i % 5 == 4, i % 2 == 1});
                end
            end
            cycle_end();
        end
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) cycle_begin(1'b0, 1'b1, 8'h2A, 1'b0, 8'($urandom));
            else        cycle_begin(1'b0, 1'b0, 8'($urandom), 1'b0, 8'($urandom));
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== exp_vec[k]) begin
                    miscompares++;
                    $display("FAIL idle_hold dut%0d cyc%0d: got %h want %h", k, i, obs(k), exp_vec[k]);
                end
            end
            vectors++;
            if ({rom_addr[0], a_valid[0]} !== {8'h2A, i == 2}) begin
                miscompares++;
                $display("FAIL idle_hold_addr cyc%0d: got %h/%b want 2a/%b", i, rom_addr[0], a_valid[0], i == 2);
            end
            cycle_end();
        end
    endtask

    task automatic test_req_drop();
        logic [7:0] a;
        a = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) cycle_begin(1'b0, 1'b1, a, 1'b0, 8'($urandom));
            else        cycle_begin(1'b0, 1'b0, 8'($urandom), 1'b0, 8'($urandom));
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== exp_vec[k]) begin
                    miscompares++;
                    $display("FAIL req_drop dut%0d cyc%0d: got %h want %h", k, i, obs(k), exp_vec[k]);
                end
            end
            cycle_end();
        end
    endtask

    task automatic test_random();
        logic r;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 63) == 0);
            cycle_begin(r, $urandom_range(0, 9) < 6, 8'($urandom),
                        $urandom_range(0, 9) < 5, 8'($urandom));
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== exp_vec[k]) begin
                    miscompares++;
                    $display("FAIL random dut%0d cyc%0d: got %h want %h", k, i, obs(k), exp_vec[k]);
                end
            end
            cycle_end();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        for (int k = 0; k < 2; k++) begin
            denied[k] = 0; m_last[k] = 8'h00; hold_a[k] = 8'h00; hold_b[k] = 8'h00;
            cur_own[k] = 0; cur_addr[k] = 8'h00;
        end
        @(negedge CLK);
        @(negedge CLK);
        test_reset();
        test_a_only();
        test_b_only();
        test_contention();
        test_idle_hold();
        test_req_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
